// File: rtl/count_pipe.sv
// -----------------------------------------------------------------------------
// count_pipe
//
// Parametrised step counter with a registered delay line. The WIDTH-bit
// counter advances by 'step' (or is loaded), and a DEPTH-stage shift line
// captures the counter's value from before the edge on every advance.
// This block is used as a stimulus/timestamp source in pipeline benches.
//
// Parameters:
//   WIDTH  counter and tap width in bits (>= 2)
//   DEPTH  number of delay-line stages   (>= 1)
//   INIT   counter reset value, truncated to WIDTH
//
// Ports:
//   clk       in   1            clock, all state updates on posedge
//   rst       in   1            asynchronous active-high reset
//   en        in   1            advance counter by step
//   load      in   1            load counter from load_val (priority over en)
//   load_val  in   WIDTH        load value
//   step      in   WIDTH        unsigned increment
//   sat_mode  in   1            1 = clamp on overflow, 0 = wrap
//                               (only honoured when COUNT_PIPE_SAT_EN is set)
//   count     out  WIDTH        counter value
//   taps      out  DEPTH*WIDTH  delay line, stage k at [k*WIDTH +: WIDTH]
//   tap_vld   out  DEPTH        per-stage valid
//   wrap      out  1            pulse: last advance overflowed and wrapped
//   sat       out  1            pulse: last advance overflowed and clamped
//
// Handshake: there is no backpressure. en and load are per-cycle request
// qualifiers sampled on every posedge; any cycle with (load | en) is an
// "advance" and shifts the delay line exactly once. Outputs are registered
// and valid every cycle; tap_vld marks which delay stages hold real samples.
//
// Configuration macro: COUNT_PIPE_SAT_EN
//   defined   : saturation logic is built, sat_mode selects clamp vs wrap
//   undefined : the counter always wraps, sat is tied low, sat_mode unused
// -----------------------------------------------------------------------------
module count_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int INIT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  input  logic [WIDTH-1:0]       step,
  input  logic                   sat_mode,
  output logic [WIDTH-1:0]       count,
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic [DEPTH-1:0]       tap_vld,
  output logic                   wrap,
  output logic                   sat
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]       count_q, count_d;
  logic [DEPTH*WIDTH-1:0] taps_q,  taps_d;
  logic [DEPTH-1:0]       vld_q,   vld_d;
  logic                   wrap_q,  wrap_d;
  logic                   sat_q,   sat_d;

  // ---------------------------------------------------------------------------
  // Adder: one extra bit so the overflow carry is visible.
  // ---------------------------------------------------------------------------
  logic             advance;
  logic [WIDTH:0]   sum;
  logic             carry;

  assign advance = load | en;
  assign sum     = {1'b0, count_q} + {1'b0, step};
  assign carry   = sum[WIDTH];

`ifdef COUNT_PIPE_SAT_EN
  logic clamp;
  assign clamp = sat_mode;
`else
  // sat_mode stays on the port list for a uniform interface but has no
  // function in this build.
  logic unused_sat_mode;
  assign unused_sat_mode = sat_mode;
`endif

  // ---------------------------------------------------------------------------
  // Counter next state. wrap/sat are pulses describing the advance that just
  // happened, so they default low and are only raised on an overflowing en.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
`ifdef COUNT_PIPE_SAT_EN
      if (carry && clamp) begin
        count_d = '1;
        sat_d   = 1'b1;
      end else begin
        count_d = sum[WIDTH-1:0];
        wrap_d  = carry;
      end
`else
      count_d = sum[WIDTH-1:0];
      wrap_d  = carry;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line next state. Stage 0 takes count_q (the value before this edge),
  // so a value placed on count reaches stage k after k+1 advances. Shifting is
  // written per stage so DEPTH == 1 needs no special slice.
  // ---------------------------------------------------------------------------
  always_comb begin
    taps_d = taps_q;
    vld_d  = vld_q;
    if (advance) begin
      taps_d[0 +: WIDTH] = count_q;
      vld_d[0]           = 1'b1;
      for (int k = 1; k < DEPTH; k++) begin
        taps_d[k*WIDTH +: WIDTH] = taps_q[(k-1)*WIDTH +: WIDTH];
        vld_d[k]                 = vld_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Everything shares one edge and uses nonblocking updates, so
  // the delay line always sees the pre-edge counter regardless of ordering.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= INIT_V;
      taps_q  <= '0;
      vld_q   <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      taps_q  <= taps_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count   = count_q;
  assign taps    = taps_q;
  assign tap_vld = vld_q;
  assign wrap    = wrap_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_count_pipe.sv
// -----------------------------------------------------------------------------
// tb_count_pipe
//
// Bench for count_pipe (WIDTH=8, DEPTH=4, INIT=1). The driver applies one
// request per cycle on the negedge and, at the same time, advances a
// reference model built from a sample history queue; the expected
// post-edge output snapshot is pushed into exp_q. A monitor pops one entry
// shortly after each posedge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_count_pipe;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int INIT = 1;
  localparam int PW   = W + D*W + D + 2;

`ifdef COUNT_PIPE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] step;
  logic         sat_mode;
  logic [W-1:0]   count;
  logic [D*W-1:0] taps;
  logic [D-1:0]   tap_vld;
  logic           wrap;
  logic           sat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  count_pipe #(.WIDTH(W), .DEPTH(D), .INIT(INIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .sat_mode (sat_mode),
    .count    (count),
    .taps     (taps),
    .tap_vld  (tap_vld),
    .wrap     (wrap),
    .sat      (sat)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [PW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;

  int m_count;     // counter value after the most recent edge
  int hist[$];     // pre-edge counter values, newest first, one per advance
  bit m_wrap;
  bit m_sat;

  function automatic logic [PW-1:0] model_pack();
    logic [D*W-1:0] t;
    logic [D-1:0]   v;
    t = '0;
    v = '0;
    for (int k = 0; k < D; k++) begin
      if (k < hist.size()) begin
        t[k*W +: W] = W'(hist[k]);
        v[k]        = 1'b1;
      end
    end
    return {W'(m_count), t, v, m_wrap, m_sat};
  endfunction

  function automatic void model_reset();
    m_count = INIT % (1 << W);
    hist.delete();
    m_wrap = 1'b0;
    m_sat  = 1'b0;
  endfunction

  function automatic logic [PW-1:0] dut_pack();
    return {count, taps, tap_vld, wrap, sat};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input bit e, input bit l, input int lv, input int st,
                       input bit sm);
    int s;
    @(negedge clk);
    en       = e;
    load     = l;
    load_val = W'(lv);
    step     = W'(st);
    sat_mode = sm;
    if (l || e) begin
      hist.push_front(m_count);
      if (hist.size() > D) void'(hist.pop_back());
    end
    m_wrap = 1'b0;
    m_sat  = 1'b0;
    if (l) begin
      m_count = lv;
    end else if (e) begin
      s = m_count + st;
      if (s >= (1 << W)) begin
        if (SAT_EN && sm) begin
          m_count = (1 << W) - 1;
          m_sat   = 1'b1;
        end else begin
          m_count = s - (1 << W);
          m_wrap  = 1'b1;
        end
      end else begin
        m_count = s;
      end
    end
    exp_q.push_back(model_pack());
  endtask

  task automatic check_reset(input string name);
    logic [PW-1:0] want;
    want = {W'(INIT), {(D*W){1'b0}}, {D{1'b0}}, 1'b0, 1'b0};
    n_checks++;
    if (dut_pack() !== want) begin
      n_fail++;
      $display("FAIL %s: got count=%h taps=%h vld=%b wrap=%b sat=%b, want %h",
               name, count, taps, tap_vld, wrap, sat, want);
    end
  endtask

  // Raise rst between clock edges and check outputs before the next posedge.
  task automatic async_reset(input string name);
    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset(name);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one expected snapshot per driven cycle, checked after the edge.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] mon_exp;
  logic [PW-1:0] mon_got;

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = dut_pack();
      n_checks++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL cycle_out t=%0t: got count=%h taps=%h vld=%b wrap=%b sat=%b | want count=%h taps=%h vld=%b wrap=%b sat=%b",
                 $time, mon_got[PW-1 -: W], mon_got[D+2 +: D*W], mon_got[2 +: D],
                 mon_got[1], mon_got[0], mon_exp[PW-1 -: W], mon_exp[D+2 +: D*W],
                 mon_exp[2 +: D], mon_exp[1], mon_exp[0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int r;
    int st;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    step     = '0;
    sat_mode = 1'b0;
    model_reset();
    #3 check_reset("reset_values");
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: count 2,3,4,5; taps fill to {1,2,3,4}
    repeat (4) drive(1, 0, 0, 1, 0);

    // Scenario 2: load 0xFE then +3 -> 0x01 with a wrap pulse
    drive(0, 1, 'hFE, 0, 0);
    drive(1, 0, 0, 3, 0);

    // Scenario 6: idle cycles, everything holds and wrap drops
    repeat (3) drive(0, 0, 'h55, 7, 0);

    // Scenario 3: sat_mode=1 overflow twice (clamps only with the macro)
    drive(0, 1, 'hFE, 0, 1);
    drive(1, 0, 0, 3, 1);
    drive(1, 0, 0, 3, 1);

    // Scenario 4: load and en together, load wins, pre-load count sampled
    drive(0, 1, 5, 0, 0);
    drive(1, 1, 'h40, 1, 0);

    // Decrement via step=0xFF across zero, then sample without increment
    drive(0, 1, 2, 0, 0);
    repeat (4) drive(1, 0, 0, 'hFF, 0);
    repeat (2) drive(1, 0, 0, 0, 0);

    // Scenario 5: two advances, async reset between edges, then resume
    async_reset("reset_clean");
    repeat (2) drive(1, 0, 0, 1, 0);
    async_reset("reset_mid_run");
    repeat (3) drive(1, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      st = 0;
      else if (r == 1) st = 'hFF;
      else             st = $urandom_range(0, 255);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 255), st, $urandom_range(0, 1) == 1);
      if (i == 200) async_reset("reset_random");
    end

    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_pipe.md
# count_pipe

Parametrised counter with a registered delay line. A WIDTH-bit accumulator advances by a programmable step, and a DEPTH-stage shift line samples the counter's pre-edge value on every advance. Every stage updates on the same edge with nonblocking semantics, so the result is independent of process ordering. The block serves as the standard stimulus/timestamp source for pipeline-ordering examples and benches in the design.

## Interface
Parameters:
- WIDTH, 8, counter and tap width in bits (≥2)
- DEPTH, 4, number of delay-line stages (≥1)
- INIT, 1, counter reset value (truncated to WIDTH)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  advance counter by step
- load  in  1  load counter from load_val; has priority over en
- load_val  in  WIDTH  load value
- step  in  WIDTH  increment, unsigned
- sat_mode  in  1  saturate instead of wrap (see Configuration)
- count  out  WIDTH  counter value
- taps  out  DEPTH*WIDTH  delay line; stage k at bits [k*WIDTH +: WIDTH]
- tap_vld  out  DEPTH  per-stage valid
- wrap  out  1  one-cycle pulse: last advance overflowed and wrapped
- sat  out  1  one-cycle pulse: last advance overflowed and clamped

## Operation
- Define advance = load | en.
- Counter:
  - load=1: count ← load_val. wrap and sat ← 0.
  - else en=1: compute sum = count + step at WIDTH+1 bits.
    - No carry: count ← sum[WIDTH-1:0].
    - Carry, wrap behaviour: count ← sum[WIDTH-1:0], wrap ← 1.
    - Carry, saturate behaviour: count ← all-ones, sat ← 1.
  - else: count holds; wrap and sat ← 0.
- wrap and sat are never both 1.
- Delay line, on advance only:
  - stage0 ← count as it was before the edge, not the new value.
  - stage k ← stage k-1, for k=1..DEPTH-1.
  - tap_vld ← {tap_vld[DEPTH-2:0], 1}.
- Without advance: the delay line and tap_vld hold.
- Result ordering: after n advances from reset, stage k holds the count value from the (n-k)-th advance boundary. tap_vld[k]=1 once n>k.
- All registers update on the same edge. The result must not depend on always-block ordering.

## Timing
- Reset values: count=INIT, taps=0, tap_vld=0, wrap=0, sat=0.
- Reset is asynchronous: outputs take reset values immediately on rst rising, without waiting for clk. The first update after release happens on the first posedge with rst=0.
- Reset asserted mid-operation discards all delay-line contents.
- Latency:
  - count reflects a request 1 cycle after the edge.
  - stage k reflects a given count value k+1 advances later.
- Simultaneous load and en: load wins and step is ignored. The delay line still advances and captures the pre-load count.
- step=0 with en=1: count holds, but the delay line advances. This is a valid "sample without increment".
- Wrap-around is modulo 2^WIDTH. step=2^WIDTH-1 is equivalent to decrement-by-1 with wrap asserted on every non-zero start value.

## Configuration
- Macro COUNT_PIPE_SAT_EN.
- Defined:
  - Saturation logic is compiled in.
  - sat_mode=1 selects clamp behaviour; sat_mode=0 selects wrap behaviour.
- Undefined:
  - sat_mode is present but ignored; the counter always wraps.
  - sat is tied to 0.
  - No saturation comparator is synthesised.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, INIT=1.
1. Release reset, en=1, step=1 for 4 cycles -> count 2,3,4,5; stage0 1,2,3,4; after cycle 4, taps={stage3..0}={1,2,3,4} and tap_vld=4'b1111.
2. load_val=0xFE with load=1, then en=1, step=3 -> count 0x01, wrap=1 for exactly one cycle, stage0=0xFE.
3. Macro defined, sat_mode=1, load 0xFE, en=1, step=3 -> count 0xFF, sat=1, wrap=0; one more advance -> count stays 0xFF, sat=1 again. Macro undefined, same stimulus -> count 0x01, sat=0.
4. count=5, then load=1, load_val=0x40, en=1, step=1 in the same cycle -> count 0x40, stage0=5, tap_vld shifts in 1.
5. Run as scenario 1 for 2 cycles, then raise rst between clock edges -> count=1, taps=0, tap_vld=0 before the next posedge; resume after release starting from 1.
6. en=0, load=0 for 3 cycles after scenario 2 -> count, taps and tap_vld unchanged; wrap=0 from the first idle cycle.
